// File: rtl/ula_multiciclo.sv
// ula_multiciclo: multi-cycle ALU for the nRisc datapath.
// Single-cycle ops take CALC+FIM; mult iterates one partial product per cycle.
// All results and flags are registered and only update on the done cycle.
module ula_multiciclo #(
   parameter int WIDTH = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic [WIDTH-1:0] F,
   output logic             igual,
   output logic             menor,
   output logic             ovf,
   output logic             busy,
   output logic             done
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {
      OCIOSO = 2'd0,
      CALC   = 2'd1,
      FIM    = 2'd2
   } estado_t;

   estado_t            estado_r;
   logic [2:0]         op_r;
   logic [WIDTH-1:0]   a_r;
   logic [WIDTH-1:0]   b_r;
   logic [WIDTH-1:0]   res_r;
   logic               ovf_r;
   logic [2*WIDTH-1:0] acc_r;
   logic [CW-1:0]      cnt_r;

   logic [WIDTH-1:0]   soma_s;
   logic [WIDTH-1:0]   sub_s;
   logic [WIDTH-1:0]   res_s;
   logic               ovf_s;
   logic               igual_s;
   logic               menor_s;
   logic [2*WIDTH-1:0] pp_s;

   // Signed overflow of a+b: operands agree in sign, result disagrees.
   function automatic logic ovf_add(input logic sa, input logic sb, input logic sr);
      return (sa == sb) && (sr != sa);
   endfunction

   // Signed overflow of a-b: operands differ in sign, result differs from a.
   function automatic logic ovf_sub(input logic sa, input logic sb, input logic sr);
      return (sa != sb) && (sr != sa);
   endfunction

   // Datapath for the single-cycle ops, the compare flags and the current partial product.
   always_comb begin
      soma_s  = a_r + b_r;
      sub_s   = a_r - b_r;
      igual_s = (a_r == b_r);
      menor_s = ($signed(a_r) < $signed(b_r));
      res_s   = {WIDTH{1'b0}};
      ovf_s   = 1'b0;
      if (b_r[cnt_r]) begin
         pp_s = {{WIDTH{1'b0}}, a_r} << cnt_r;
      end else begin
         pp_s = {(2*WIDTH){1'b0}};
      end
      case (op_r)
         3'b000: begin
            res_s = soma_s;
            ovf_s = ovf_add(a_r[WIDTH-1], b_r[WIDTH-1], soma_s[WIDTH-1]);
         end
         3'b001: begin
            res_s = sub_s;
            ovf_s = ovf_sub(a_r[WIDTH-1], b_r[WIDTH-1], sub_s[WIDTH-1]);
         end
         3'b010:  res_s = a_r & b_r;
         3'b011:  res_s = a_r | b_r;
         3'b100:  res_s = {{(WIDTH-1){1'b0}}, igual_s};
         3'b101:  res_s = a_r ^ b_r;
         3'b111:  res_s = {{(WIDTH-1){1'b0}}, menor_s};
         default: res_s = {WIDTH{1'b0}};
      endcase
   end

   // Control FSM with operand capture, mult accumulation and registered outputs.
   always_ff @(posedge clock) begin
      if (reset) begin
         estado_r <= OCIOSO;
         op_r     <= 3'b000;
         a_r      <= {WIDTH{1'b0}};
         b_r      <= {WIDTH{1'b0}};
         res_r    <= {WIDTH{1'b0}};
         ovf_r    <= 1'b0;
         acc_r    <= {(2*WIDTH){1'b0}};
         cnt_r    <= {CW{1'b0}};
         F        <= {WIDTH{1'b0}};
         igual    <= 1'b0;
         menor    <= 1'b0;
         ovf      <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         case (estado_r)
            OCIOSO: begin
               done <= 1'b0;
               if (start) begin
                  op_r     <= op;
                  a_r      <= A;
                  b_r      <= B;
                  acc_r    <= {(2*WIDTH){1'b0}};
                  cnt_r    <= {CW{1'b0}};
                  busy     <= 1'b1;
                  estado_r <= CALC;
               end else begin
                  busy <= 1'b0;
               end
            end
            CALC: begin
               if (op_r == 3'b110) begin
                  acc_r <= acc_r + pp_s;
                  if (cnt_r == CW'(WIDTH-1)) begin
                     estado_r <= FIM;
                  end else begin
                     cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
                  end
               end else begin
                  res_r    <= res_s;
                  ovf_r    <= ovf_s;
                  estado_r <= FIM;
               end
            end
            FIM: begin
               done  <= 1'b1;
               igual <= igual_s;
               menor <= menor_s;
               if (op_r == 3'b110) begin
                  F   <= acc_r[WIDTH-1:0];
                  ovf <= |acc_r[2*WIDTH-1:WIDTH];
               end else begin
                  F   <= res_r;
                  ovf <= ovf_r;
               end
               cnt_r    <= {CW{1'b0}};
               estado_r <= OCIOSO;
            end
            default: begin
               estado_r <= OCIOSO;
               busy     <= 1'b0;
               done     <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ula_multiciclo.sv
// Self-checking bench for ula_multiciclo: directed cases plus random ops
// compared against an arithmetic reference model.
module tb_ula_multiciclo;

   localparam int W = 8;

   logic         clock;
   logic         reset;
   logic         start;
   logic [2:0]   op;
   logic [W-1:0] A;
   logic [W-1:0] B;
   logic [W-1:0] F;
   logic         igual;
   logic         menor;
   logic         ovf;
   logic         busy;
   logic         done;

   int checks = 0;
   int errors = 0;

   ula_multiciclo #(.WIDTH(W)) dut (
      .clock(clock), .reset(reset), .start(start), .op(op), .A(A), .B(B),
      .F(F), .igual(igual), .menor(menor), .ovf(ovf), .busy(busy), .done(done)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic longint to_signed(input logic [W-1:0] v);
      longint x;
      x = longint'(v);
      if (x >= (longint'(1) << (W-1))) x = x - (longint'(1) << W);
      return x;
   endfunction

   // Reference model: plain integer arithmetic on the operand values.
   task automatic model(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        output logic [W-1:0] ef, output logic eo, output logic ei, output logic em);
      longint ua, ub, sa, sb, r, lim;
      ua  = longint'(a);
      ub  = longint'(b);
      sa  = to_signed(a);
      sb  = to_signed(b);
      lim = longint'(1) << (W-1);
      ei  = (ua == ub);
      em  = (sa < sb);
      eo  = 1'b0;
      case (o)
         3'd0: begin r = sa + sb; eo = (r >= lim) || (r < -lim); r = ua + ub; end
         3'd1: begin r = sa - sb; eo = (r >= lim) || (r < -lim); r = ua - ub; end
         3'd2: r = longint'(a & b);
         3'd3: r = longint'(a | b);
         3'd4: r = ei ? 1 : 0;
         3'd5: r = longint'(a ^ b);
         3'd6: begin r = ua * ub; eo = (r >= (longint'(1) << W)); end
         default: r = em ? 1 : 0;
      endcase
      ef = W'(r);
   endtask

   // Issue one op, check hold-while-busy, latency, results and return to idle.
   task automatic run_op(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit inject);
      logic [W-1:0] ef, fp;
      logic eo, ei, em, ip, mp, op_prev;
      int lat;
      bit seen;
      model(o, a, b, ef, eo, ei, em);
      @(negedge clock);
      op = o; A = a; B = b; start = 1'b1;
      @(posedge clock); #1;
      check("busy_accept", busy, 1);
      fp = F; ip = igual; mp = menor; op_prev = ovf;
      @(negedge clock);
      start = 1'b0;
      A = W'($urandom); B = W'($urandom); op = 3'($urandom);
      lat = 0;
      seen = 0;
      while (!seen && lat < W + 6) begin
         @(posedge clock); #1;
         lat++;
         if (done) begin
            seen = 1;
         end else begin
            check("hold_F", F, fp);
            check("hold_flags", {igual, menor, ovf}, {ip, mp, op_prev});
            check("busy_calc", busy, 1);
            if (inject && lat == 3) begin
               start = 1'b1; op = 3'd0; A = 8'h11; B = 8'h22;
            end
            if (inject && lat == 4) start = 1'b0;
         end
      end
      start = 1'b0;
      if (seen) begin
         check("latency", lat, (o == 3'd6) ? W + 1 : 2);
         check("F", F, ef);
         check("ovf", ovf, eo);
         check("igual", igual, ei);
         check("menor", menor, em);
         check("busy_done", busy, 1);
      end else begin
         check("done_timeout", 0, 1);
      end
      @(posedge clock); #1;
      check("done_pulse", done, 0);
      check("busy_idle", busy, 0);
      check("F_after", F, ef);
   endtask

   initial begin
      bit seen;
      reset = 1'b1; start = 1'b0; op = 3'd0; A = '0; B = '0;
      repeat (2) @(posedge clock);
      #1;
      check("rst_F", F, 0);
      check("rst_flags", {igual, menor, ovf, busy, done}, 0);
      @(negedge clock);
      reset = 1'b0;

      run_op(3'd1, 8'h07, 8'h04, 0);
      run_op(3'd0, 8'h7F, 8'h01, 0);
      run_op(3'd1, 8'h80, 8'h01, 0);
      run_op(3'd7, 8'hFF, 8'h01, 0);
      run_op(3'd4, 8'h07, 8'h07, 0);
      run_op(3'd6, 8'd13, 8'd11, 0);
      run_op(3'd6, 8'd20, 8'd20, 0);
      run_op(3'd6, 8'hFF, 8'h00, 0);
      run_op(3'd6, 8'hFF, 8'hFF, 0);
      run_op(3'd2, 8'hF0, 8'h3C, 0);
      run_op(3'd3, 8'hF0, 8'h3C, 0);
      run_op(3'd5, 8'hF0, 8'h3C, 0);

      // start during mult must be ignored; then soma proceeds normally
      run_op(3'd6, 8'd9, 8'd7, 1);
      run_op(3'd0, 8'h11, 8'h22, 0);

      // reset mid-mult: no done, outputs cleared
      @(negedge clock);
      op = 3'd6; A = 8'd13; B = 8'd11; start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      repeat (3) @(negedge clock);
      reset = 1'b1;
      @(posedge clock); #1;
      check("rst_mid_F", F, 0);
      check("rst_mid_flags", {igual, menor, ovf, busy, done}, 0);
      @(negedge clock);
      reset = 1'b0;
      seen = 0;
      repeat (W + 3) begin
         @(posedge clock); #1;
         if (done) seen = 1;
      end
      check("no_done_after_rst", seen, 0);
      run_op(3'd1, 8'd9, 8'd2, 0);

      for (int i = 0; i < 40; i++) begin
         run_op(3'($urandom_range(7, 0)), W'($urandom), W'($urandom), 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
